// File: rtl/pll_drp_pkg.sv
// rtl/pll_drp_pkg.sv - shared constants, types and helpers for the PLL DRP controller
package pll_drp_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_RST_ON    = 4'd1;
    localparam state_t ST_RD        = 4'd2;
    localparam state_t ST_RD_WAIT   = 4'd3;
    localparam state_t ST_WR        = 4'd4;
    localparam state_t ST_WR_WAIT   = 4'd5;
    localparam state_t ST_RST_OFF   = 4'd6;
    localparam state_t ST_WAIT_LOCK = 4'd7;

    localparam logic [6:0] ADDR_CLKOUT0_REG1  = 7'h08;
    localparam logic [6:0] ADDR_CLKOUT0_REG2  = 7'h09;
    localparam logic [6:0] ADDR_CLKFBOUT_REG1 = 7'h14;
    localparam logic [6:0] ADDR_CLKFBOUT_REG2 = 7'h15;

    localparam logic [15:0] KEEP_REG1 = 16'h1000;
    localparam logic [15:0] KEEP_REG2 = 16'hFC00;

    localparam logic [6:0] MULT_MIN = 7'd2;
    localparam logic [6:0] MULT_MAX = 7'd64;
    localparam logic [7:0] DIV_MIN  = 8'd1;
    localparam logic [7:0] DIV_MAX  = 8'd128;

    typedef struct packed {
        logic [5:0] high;
        logic [5:0] low;
        logic       edge_bit;
        logic       nocount;
    } cnt_enc_t;

    function automatic logic [6:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADDR_CLKOUT0_REG1;
            2'd1:    return ADDR_CLKOUT0_REG2;
            2'd2:    return ADDR_CLKFBOUT_REG1;
            default: return ADDR_CLKFBOUT_REG2;
        endcase
    endfunction

    function automatic logic [15:0] reg_keep(input logic [1:0] idx);
        return idx[0] ? KEEP_REG2 : KEEP_REG1;
    endfunction

    // ClkReg1 carries high/low counts, ClkReg2 carries edge/nocount (phase/delay cleared)
    function automatic logic [15:0] reg_bits(input cnt_enc_t c, input logic second);
        if (second)
            return {6'd0, 2'b00, c.edge_bit, c.nocount, 6'd0};
        return {3'b000, 1'b0, c.high, c.low};
    endfunction

endpackage

// File: rtl/pll_drp_cnt_enc.sv
// rtl/pll_drp_cnt_enc.sv - divide value to PLL high/low/edge/nocount count encoding
module pll_drp_cnt_enc
    import pll_drp_pkg::*;
(
    input  logic [7:0] n,
    output cnt_enc_t   enc
);

    // Truncation to 6 bits maps a count of 64 onto 6'd0, as the PLL expects
    always_comb begin
        enc.high     = 6'(n >> 1);
        enc.low      = 6'(n - (n >> 1));
        enc.edge_bit = n[0];
        enc.nocount  = 1'b0;
        if (n == 8'd1) begin
            enc.high     = 6'd1;
            enc.low      = 6'd1;
            enc.edge_bit = 1'b0;
            enc.nocount  = 1'b1;
        end
    end

endmodule

// File: rtl/pll_drp_ctrl.sv
// rtl/pll_drp_ctrl.sv - DRP read-modify-write initiator reprogramming PLL CLKFBOUT/CLKOUT0
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int DRP_TIMEOUT  = 255,
    parameter int LOCK_TIMEOUT = 65535
)
(
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [6:0]  cfg_mult_i,
    input  logic [7:0]  cfg_div_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [6:0]  drp_daddr_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        pll_rst_o,
    input  logic        pll_locked_i
);

    localparam int TMAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
    localparam int CW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] DRP_LAST  = CW'(DRP_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    state_t        state;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [6:0]    mult_q;
    logic [7:0]    div_q;
    logic [CW-1:0] wait_cnt;
    logic          lock_meta;
    logic          lock_sync;
    logic          range_ok;
    cnt_enc_t      mult_enc;
    cnt_enc_t      div_enc;
    cnt_enc_t      sel_enc;
    logic [15:0]   merged;

    pll_drp_cnt_enc u_enc_mult (
        .n   ({1'b0, mult_q}),
        .enc (mult_enc)
    );

    pll_drp_cnt_enc u_enc_div (
        .n   (div_q),
        .enc (div_enc)
    );

    assign range_ok = (cfg_mult_i >= MULT_MIN) && (cfg_mult_i <= MULT_MAX) &&
                      (cfg_div_i >= DIV_MIN) && (cfg_div_i <= DIV_MAX);
    assign idx_next = idx + 2'd1;
    // Indices 0/1 program CLKOUT0 from div, 2/3 program CLKFBOUT from mult
    assign sel_enc  = idx[1] ? mult_enc : div_enc;
    assign merged   = (drp_do_i & reg_keep(idx)) | reg_bits(sel_enc, idx[0]);

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            mult_q      <= 7'd0;
            div_q       <= 8'd0;
            wait_cnt    <= '0;
            lock_meta   <= 1'b0;
            lock_sync   <= 1'b0;
            cfg_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            drp_daddr_o <= 7'd0;
            drp_den_o   <= 1'b0;
            drp_dwe_o   <= 1'b0;
            drp_di_o    <= 16'd0;
            pll_rst_o   <= 1'b0;
        end else begin
            lock_meta <= pll_locked_i;
            lock_sync <= lock_meta;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            drp_den_o <= 1'b0;
            drp_dwe_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cfg_valid_i && cfg_ready_o) begin
                        if (range_ok) begin
                            mult_q      <= cfg_mult_i;
                            div_q       <= cfg_div_i;
                            idx         <= 2'd0;
                            pll_rst_o   <= 1'b1;
                            cfg_ready_o <= 1'b0;
                            busy_o      <= 1'b1;
                            state       <= ST_RST_ON;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                ST_RST_ON: begin
                    drp_den_o   <= 1'b1;
                    drp_daddr_o <= reg_addr(idx);
                    state       <= ST_RD;
                end
                ST_RD: begin
                    wait_cnt <= '0;
                    state    <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (drp_drdy_i) begin
                        drp_di_o  <= merged;
                        drp_den_o <= 1'b1;
                        drp_dwe_o <= 1'b1;
                        state     <= ST_WR;
                    end else if (wait_cnt == DRP_LAST) begin
                        err_o       <= 1'b1;
                        cfg_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_WR: begin
                    wait_cnt <= '0;
                    state    <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (drp_drdy_i) begin
                        if (idx == 2'd3) begin
                            state <= ST_RST_OFF;
                        end else begin
                            idx         <= idx_next;
                            drp_den_o   <= 1'b1;
                            drp_daddr_o <= reg_addr(idx_next);
                            state       <= ST_RD;
                        end
                    end else if (wait_cnt == DRP_LAST) begin
                        err_o       <= 1'b1;
                        cfg_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_RST_OFF: begin
                    pll_rst_o <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync) begin
                        done_o      <= 1'b1;
                        cfg_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (wait_cnt == LOCK_LAST) begin
                        err_o       <= 1'b1;
                        cfg_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    cfg_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    pll_rst_o   <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb/tb_pll_drp_ctrl.sv - self-checking scoreboard bench for pll_drp_ctrl
module tb_pll_drp_ctrl;

    localparam int DRP_TO  = 255;
    localparam int LOCK_TO = 300;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [6:0]  cfg_mult_i = 7'd0;
    logic [7:0]  cfg_div_i = 8'd0;
    logic        busy_o, done_o, err_o;
    logic [6:0]  drp_daddr_o;
    logic        drp_den_o, drp_dwe_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i = 16'h0;
    logic        drp_drdy_i = 1'b0;
    logic        pll_rst_o;
    logic        pll_locked_i;

    logic [15:0] rd_val = 16'h0;
    logic        drdy_en = 1'b1;
    logic        lock_en = 1'b1;
    int          cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  done_cnt, err_cnt, den_cnt, done_cyc, err_cyc, acc_cyc, first_den_cyc;
    bit  rst_ever, rst_all_writes;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // DRP slave: answers one cycle after den when enabled
    always @(posedge clk_sys) begin
        drp_drdy_i <= drp_den_o && drdy_en;
        drp_do_i   <= (drp_den_o && !drp_dwe_o) ? rd_val : 16'h0;
    end

    assign pll_locked_i = lock_en && !pll_rst_o;

    pll_drp_ctrl #(
        .DRP_TIMEOUT  (DRP_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_mult_i   (cfg_mult_i),
        .cfg_div_i    (cfg_div_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .drp_daddr_o  (drp_daddr_o),
        .drp_den_o    (drp_den_o),
        .drp_dwe_o    (drp_dwe_o),
        .drp_di_o     (drp_di_o),
        .drp_do_i     (drp_do_i),
        .drp_drdy_i   (drp_drdy_i),
        .pll_rst_o    (pll_rst_o),
        .pll_locked_i (pll_locked_i)
    );

    function automatic logic [15:0] model_word(input int idx, input int n, input logic [15:0] rd);
        int hi, lo;
        logic [15:0] w;
        if (n == 1) begin
            hi = 1;
            lo = 1;
        end else begin
            hi = n / 2;
            lo = n - hi;
        end
        hi = hi % 64;
        lo = lo % 64;
        if (idx % 2 == 0)
            w = (rd & 16'h1000) | 16'(hi * 64 + lo);
        else
            w = (rd & 16'hFC00) | 16'((n % 2 == 1 && n != 1) ? 128 : 0) | 16'((n == 1) ? 64 : 0);
        return w;
    endfunction

    // Drives one request and records everything the DUT does until done/err plus a short tail
    task automatic run_request(input logic [6:0] m, input logic [7:0] d, input int max_cyc);
        int tail;
        obs_q.delete();
        done_cnt = 0; err_cnt = 0; den_cnt = 0;
        done_cyc = -1; err_cyc = -1; first_den_cyc = -1;
        rst_ever = 0; rst_all_writes = 1;
        @(negedge clk_sys);
        cfg_mult_i  = m;
        cfg_div_i   = d;
        cfg_valid_i = 1'b1;
        acc_cyc = cyc + 1;
        @(negedge clk_sys);
        cfg_valid_i = 1'b0;
        tail = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if (drp_den_o) begin
                den_cnt++;
                if (first_den_cyc < 0) first_den_cyc = cyc;
            end
            if (drp_den_o && drp_dwe_o) begin
                obs_q.push_back('{addr: drp_daddr_o, data: drp_di_o});
                if (!pll_rst_o) rst_all_writes = 0;
            end
            if (pll_rst_o) rst_ever = 1;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (err_o) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (tail < 0 && (done_o || err_o)) tail = 3;
            if (tail == 0) break;
            if (tail > 0) tail--;
            @(negedge clk_sys);
        end
    endtask

    task automatic test_reset;
        rst_sys_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        n_cmp++;
        if ({cfg_ready_o, busy_o, done_o, err_o, drp_den_o, drp_dwe_o, pll_rst_o} !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b want=1000000",
                     {cfg_ready_o, busy_o, done_o, err_o, drp_den_o, drp_dwe_o, pll_rst_o});
        end
        n_cmp++;
        if (drp_daddr_o !== 7'h0) begin
            n_err++;
            $display("FAIL reset_daddr got=%h want=00", drp_daddr_o);
        end
        n_cmp++;
        if (drp_di_o !== 16'h0) begin
            n_err++;
            $display("FAIL reset_di got=%h want=0000", drp_di_o);
        end
        rst_sys_n = 1'b1;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic test_program;
        int          cm[6];
        int          cd[6];
        logic [15:0] crd[6];
        logic [15:0] cw[6][4];
        logic [6:0]  addrs[4];
        wr_t e, o;
        addrs[0] = 7'h08; addrs[1] = 7'h09; addrs[2] = 7'h14; addrs[3] = 7'h15;
        cm[0] = 12; cd[0] = 48;  crd[0] = 16'h0000;
        cw[0][0] = 16'h0618; cw[0][1] = 16'h0000; cw[0][2] = 16'h0186; cw[0][3] = 16'h0000;
        cm[1] = 12; cd[1] = 5;   crd[1] = 16'hFFFF;
        cw[1][0] = 16'h1083; cw[1][1] = 16'hFC80; cw[1][2] = 16'h1186; cw[1][3] = 16'hFC00;
        cm[2] = 64; cd[2] = 1;   crd[2] = 16'h0000;
        cw[2][0] = 16'h0041; cw[2][1] = 16'h0040; cw[2][2] = 16'h0820; cw[2][3] = 16'h0000;
        cm[3] = 2;  cd[3] = 128; crd[3] = 16'h0000;
        cw[3][0] = 16'h0000; cw[3][1] = 16'h0000; cw[3][2] = 16'h0041; cw[3][3] = 16'h0000;
        for (int c = 4; c < 6; c++) begin
            cm[c]  = int'($urandom_range(2, 64));
            cd[c]  = int'($urandom_range(1, 128));
            crd[c] = 16'($urandom);
            cw[c][0] = model_word(0, cd[c], crd[c]);
            cw[c][1] = model_word(1, cd[c], crd[c]);
            cw[c][2] = model_word(2, cm[c], crd[c]);
            cw[c][3] = model_word(3, cm[c], crd[c]);
        end
        for (int c = 0; c < 6; c++) begin
            rd_val = crd[c];
            for (int k = 0; k < 4; k++) exp_q.push_back('{addr: addrs[k], data: cw[c][k]});
            run_request(7'(cm[c]), 8'(cd[c]), 60);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs_q.size() == 0) begin
                    n_err++;
                    $display("FAIL prog%0d_write_missing want=%h<-%h", c, e.addr, e.data);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin
                        n_err++;
                        $display("FAIL prog%0d_write got=%h<-%h want=%h<-%h", c, o.addr, o.data, e.addr, e.data);
                    end
                end
            end
            n_cmp++;
            if (obs_q.size() != 0) begin
                n_err++;
                $display("FAIL prog%0d_extra_writes got=%0d want=0", c, obs_q.size());
            end
            n_cmp++;
            if (done_cnt != 1 || err_cnt != 0) begin
                n_err++;
                $display("FAIL prog%0d_done got=%0d/%0d want=1/0", c, done_cnt, err_cnt);
            end
            n_cmp++;
            if (done_cyc - acc_cyc != 21) begin
                n_err++;
                $display("FAIL prog%0d_latency got=%0d want=21", c, done_cyc - acc_cyc);
            end
            n_cmp++;
            if (!rst_all_writes || den_cnt != 8) begin
                n_err++;
                $display("FAIL prog%0d_rst_den got=%0d/%0d want=1/8", c, rst_all_writes, den_cnt);
            end
        end
    endtask

    task automatic test_range_err;
        logic [6:0] bm[4];
        logic [7:0] bd[4];
        bm[0] = 7'd12; bd[0] = 8'd0;
        bm[1] = 7'd1;  bd[1] = 8'd48;
        bm[2] = 7'd65; bd[2] = 8'd48;
        bm[3] = 7'd12; bd[3] = 8'd129;
        for (int c = 0; c < 4; c++) begin
            run_request(bm[c], bd[c], 10);
            n_cmp++;
            if (err_cnt != 1 || err_cyc != acc_cyc) begin
                n_err++;
                $display("FAIL range%0d_err got=%0d@%0d want=1@%0d", c, err_cnt, err_cyc, acc_cyc);
            end
            n_cmp++;
            if (den_cnt != 0 || rst_ever || !cfg_ready_o) begin
                n_err++;
                $display("FAIL range%0d_side got=den%0d rst%0d rdy%0d want=den0 rst0 rdy1",
                         c, den_cnt, rst_ever, cfg_ready_o);
            end
        end
    endtask

    task automatic test_drp_timeout;
        drdy_en = 1'b0;
        run_request(7'd12, 8'd48, DRP_TO + 20);
        n_cmp++;
        if (err_cnt != 1 || err_cyc != first_den_cyc + 1 + DRP_TO) begin
            n_err++;
            $display("FAIL drp_timeout_err got=%0d@%0d want=1@%0d", err_cnt, err_cyc, first_den_cyc + 1 + DRP_TO);
        end
        n_cmp++;
        if (pll_rst_o !== 1'b1 || cfg_ready_o !== 1'b1 || den_cnt != 1) begin
            n_err++;
            $display("FAIL drp_timeout_state got=rst%b rdy%b den%0d want=rst1 rdy1 den1", pll_rst_o, cfg_ready_o, den_cnt);
        end
        drdy_en = 1'b1;
        run_request(7'd20, 8'd10, 60);
        n_cmp++;
        if (done_cnt != 1 || err_cnt != 0) begin
            n_err++;
            $display("FAIL drp_timeout_recover got=%0d/%0d want=1/0", done_cnt, err_cnt);
        end
    endtask

    task automatic test_lock_timeout;
        lock_en = 1'b0;
        run_request(7'd30, 8'd6, LOCK_TO + 40);
        n_cmp++;
        if (err_cnt != 1 || done_cnt != 0 || err_cyc != acc_cyc + 18 + LOCK_TO) begin
            n_err++;
            $display("FAIL lock_timeout got=err%0d done%0d @%0d want=err1 done0 @%0d",
                     err_cnt, done_cnt, err_cyc, acc_cyc + 18 + LOCK_TO);
        end
        n_cmp++;
        if (pll_rst_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL lock_timeout_state got=rst%b rdy%b want=rst0 rdy1", pll_rst_o, cfg_ready_o);
        end
        lock_en = 1'b1;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic test_mid_reset;
        bit seen = 0;
        rd_val = 16'h0;
        @(negedge clk_sys);
        cfg_mult_i = 7'd12; cfg_div_i = 8'd48; cfg_valid_i = 1'b1;
        @(negedge clk_sys);
        cfg_valid_i = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (drp_den_o && drp_dwe_o && drp_daddr_o == 7'h14) seen = 1;
            else @(negedge clk_sys);
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL midrst_write2 got=none want=write to 14");
        end
        @(negedge clk_sys);
        rst_sys_n = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if (cfg_ready_o !== 1'b1 || pll_rst_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state got=rdy%b rst%b busy%b want=rdy1 rst0 busy0", cfg_ready_o, pll_rst_o, busy_o);
        end
        rst_sys_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        run_request(7'd12, 8'd48, 60);
        n_cmp++;
        if (done_cnt != 1 || done_cyc - acc_cyc != 21 || obs_q.size() != 4) begin
            n_err++;
            $display("FAIL midrst_recover got=done%0d lat%0d wr%0d want=done1 lat21 wr4",
                     done_cnt, done_cyc - acc_cyc, obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_range_err();
        test_drp_timeout();
        test_lock_timeout();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
